fifo: RTL and testbench

//  Synchronous single-clock FIFO queue of DWIDTH-bit words, QUEUE_SIZE deep.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 26 ++
 rtl/fifo.sv | 76 +++++++
 tb/tb_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO: pointer width and wrapping pointer increment.
// Depths need not be powers of two, so wrap is an explicit compare.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// QUEUE_SIZE x DWIDTH register array: one synchronous write port, one combinational read port.
// Contents are not reset; the FIFO pointers decide which entries are meaningful.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int QUEUE_SIZE = 21,
  parameter int PW         = ptr_w(QUEUE_SIZE)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [PW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [QUEUE_SIZE];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO: head word visible the cycle after it is written.
// Enqueue is refused while full (even with a concurrent pop); pops are ignored while empty.
module fifo
  import fifo_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int QUEUE_SIZE = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_enque_en,
  output logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              out_deque_en,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data
);

  localparam int PW = ptr_w(QUEUE_SIZE);
  localparam int CW = $clog2(QUEUE_SIZE + 1);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              enq, deq;
  logic [DWIDTH-1:0] head_dat;

  assign in_valid  = (count_q != CW'(QUEUE_SIZE));
  assign out_valid = (count_q != '0);

  // Handshakes are qualified by the registered state, so full/empty gate both sides.
  assign enq = in_enque_en && in_valid;
  assign deq = out_deque_en && out_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = PW'(ptr_inc(int'(wr_ptr_q), QUEUE_SIZE));
    if (deq) rd_ptr_d = PW'(ptr_inc(int'(rd_ptr_q), QUEUE_SIZE));
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .DWIDTH     (DWIDTH),
    .QUEUE_SIZE (QUEUE_SIZE),
    .PW         (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_dat)
  );

  // Stale storage must never leak out while the queue is empty.
  assign out_data = out_valid ? head_dat : '0;

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo (64 x 21): reset, fill, drain, wrap ordering, full/empty boundaries, async reset.
module tb_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_enque_en = 1'b0;
  logic        in_valid;
  logic [63:0] in_data = '0;
  logic        out_deque_en = 1'b0;
  logic        out_valid;
  logic [63:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo #(
    .DWIDTH     (64),
    .QUEUE_SIZE (21)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_enque_en  (in_enque_en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_deque_en (out_deque_en),
    .out_valid    (out_valid),
    .out_data     (out_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] nxt;

    // Reset held for two cycles, then released.
    #1 rst = 1'b0;
    tick();
    tick();
    check("rst_in_valid", in_valid, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b1;
    tick();
    check("idle_in_valid", in_valid, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_out_data", out_data, 0);

    // Fill with a constant word: exactly 21 accepted writes.
    in_enque_en = 1'b1;
    in_data     = 64'd114514;
    for (int i = 0; i < 21; i++) begin
      check("fill_in_valid_pre", in_valid, 1);
      tick();
      check("fill_out_valid", out_valid, 1);
      check("fill_out_data", out_data, 64'd114514);
    end
    check("full_in_valid", in_valid, 0);
    in_data = 64'd999;
    tick();
    check("full_ignored_in_valid", in_valid, 0);
    check("full_ignored_head", out_data, 64'd114514);

    // Drain: 21 pops, in_valid rises after the first.
    in_enque_en  = 1'b0;
    out_deque_en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      check("drain_out_valid", out_valid, 1);
      check("drain_out_data", out_data, 64'd114514);
      tick();
      check("drain_in_valid", in_valid, 1);
    end
    check("drained_out_valid", out_valid, 0);
    check("drained_out_data", out_data, 0);

    // Pop while empty changes nothing.
    tick();
    check("empty_pop_out_valid", out_valid, 0);
    check("empty_pop_in_valid", in_valid, 1);
    check("empty_pop_out_data", out_data, 0);

    // Order and wrap: push 1..15, then push 16..30 while popping, then drain.
    out_deque_en = 1'b0;
    in_enque_en  = 1'b1;
    for (int v = 1; v <= 15; v++) begin
      in_data = 64'(v);
      tick();
    end
    check("wrap_head_1", out_data, 1);
    nxt = 64'd1;
    out_deque_en = 1'b1;
    for (int v = 16; v <= 30; v++) begin
      in_data = 64'(v);
      check("wrap_mid_pop", out_data, nxt);
      tick();
      nxt++;
      check("wrap_mid_out_valid", out_valid, 1);
      check("wrap_mid_in_valid", in_valid, 1);
    end
    in_enque_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("wrap_drain_pop", out_data, nxt);
      tick();
      nxt++;
    end
    check("wrap_done_out_valid", out_valid, 0);
    check("wrap_done_count", nxt, 64'd31);

    // Simultaneous enq+deq at full: only the pop happens.
    out_deque_en = 1'b0;
    in_enque_en  = 1'b1;
    for (int i = 0; i < 21; i++) begin
      in_data = 64'(100 + i);
      tick();
    end
    check("full2_in_valid", in_valid, 0);
    in_data      = 64'hDEAD;
    out_deque_en = 1'b1;
    tick();
    check("full_both_in_valid", in_valid, 1);
    check("full_both_head", out_data, 64'd101);
    in_enque_en = 1'b0;
    for (int i = 1; i < 21; i++) begin
      check("full_both_drain", out_data, 64'(100 + i));
      tick();
    end
    check("full_both_empty", out_valid, 0);

    // Simultaneous enq+deq at empty: enqueue only.
    in_enque_en = 1'b1;
    in_data     = 64'd55;
    tick();
    check("empty_both_out_valid", out_valid, 1);
    check("empty_both_head", out_data, 64'd55);
    in_enque_en = 1'b0;
    tick();
    check("empty_both_drained", out_valid, 0);

    // Async reset mid-traffic with 7 entries.
    out_deque_en = 1'b0;
    in_enque_en  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 64'(200 + i);
      tick();
    end
    in_enque_en = 1'b0;
    check("pre_arst_head", out_data, 64'd200);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_valid", in_valid, 1);
    check("arst_out_data", out_data, 0);
    tick();
    rst = 1'b1;
    in_enque_en = 1'b1;
    in_data     = 64'd77;
    tick();
    in_enque_en = 1'b0;
    check("post_arst_head", out_data, 64'd77);
    check("post_arst_out_valid", out_valid, 1);
    out_deque_en = 1'b1;
    tick();
    out_deque_en = 1'b0;
    check("post_arst_single", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
